// File: rtl/bus_cycle_ctrl_if.sv
// bus_cycle_ctrl_if: 68000-side bus signals between the CPU and the bus cycle controller.
//   master (CPU side) : drives AS, RW, FC, ADDR; observes chip selects and acknowledges
//   slave  (controller): observes AS, RW, FC, ADDR; drives CS_ROM/CS_RAM/CS_IO,
//                        DTACK, VPA, BERR (all active low) and BOOT (1 = overlay released)
interface bus_cycle_ctrl_if;
    logic       AS;
    logic       RW;
    logic [2:0] FC;
    logic [3:0] ADDR;
    logic       CS_ROM;
    logic       CS_RAM;
    logic       CS_IO;
    logic       DTACK;
    logic       VPA;
    logic       BERR;
    logic       BOOT;

    modport master (
        output AS, RW, FC, ADDR,
        input  CS_ROM, CS_RAM, CS_IO, DTACK, VPA, BERR, BOOT
    );

    modport slave (
        input  AS, RW, FC, ADDR,
        output CS_ROM, CS_RAM, CS_IO, DTACK, VPA, BERR, BOOT
    );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: sequences each 68000 bus cycle. Decodes FC/A[23:20] into chip
// selects (with a read-only ROM overlay until BOOT_CYCLES cycles complete), inserts
// per-region wait states before DTACK, answers IACK with VPA and times out
// unacknowledged cycles with BERR.
//   CLK : CPU clock, rising edge
//   RST : asynchronous active-high reset
//   bus : slave side of bus_cycle_ctrl_if (AS/RW/FC/ADDR in; CS_*, DTACK, VPA, BERR, BOOT out)
module bus_cycle_ctrl #(
    parameter int unsigned ROM_WAIT    = 2,
    parameter int unsigned RAM_WAIT    = 0,
    parameter int unsigned IO_WAIT     = 4,
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned BOOT_CYCLES = 8
) (
    input  logic            CLK,
    input  logic            RST,
    bus_cycle_ctrl_if.slave bus
);

    localparam int unsigned WAIT_W = 4;
    localparam int unsigned TMO_W  = 8;
    localparam int unsigned BOOT_W = 4;
    localparam int unsigned CS_W   = 3;

    // Timeout counter value seen on the edge that must raise BERR (edge N+TIMEOUT).
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

    // Active-low chip select patterns, ordered {ROM, RAM, IO}.
    localparam logic [CS_W-1:0] CS_NONE = 3'b111;
    localparam logic [CS_W-1:0] CS_ROM  = 3'b011;
    localparam logic [CS_W-1:0] CS_RAM  = 3'b101;
    localparam logic [CS_W-1:0] CS_IO   = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_IACK,
        S_UNMAPPED,
        S_ACK
    } state_t;

    state_t              state;
    logic [CS_W-1:0]     cs_q;
    logic                dtack_q;
    logic                vpa_q;
    logic                berr_q;
    logic                boot_q;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [BOOT_W-1:0]   boot_cnt;

    logic [CS_W-1:0]     dec_cs;
    logic [WAIT_W-1:0]   dec_wait;
    state_t              dec_state;

    // Region decode from the current bus inputs; only used on the cycle-start edge.
    always_comb begin
        dec_cs    = CS_NONE;
        dec_wait  = '0;
        dec_state = S_UNMAPPED;
        if (bus.FC == 3'b111) begin
            dec_state = S_IACK;
        end else if (!boot_q && bus.RW) begin
            // Boot overlay: every read goes to ROM until BOOT is set.
            dec_cs    = CS_ROM;
            dec_wait  = WAIT_W'(ROM_WAIT);
            dec_state = S_WAIT;
        end else if (bus.ADDR <= 4'hB) begin
            dec_cs    = CS_RAM;
            dec_wait  = WAIT_W'(RAM_WAIT);
            dec_state = S_WAIT;
        end else if (bus.ADDR == 4'hE) begin
            dec_cs    = CS_ROM;
            dec_wait  = WAIT_W'(ROM_WAIT);
            dec_state = S_WAIT;
        end else if (bus.ADDR == 4'hF) begin
            dec_cs    = CS_IO;
            dec_wait  = WAIT_W'(IO_WAIT);
            dec_state = S_WAIT;
        end
    end

    // Bus cycle FSM with registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            cs_q     <= CS_NONE;
            dtack_q  <= 1'b1;
            vpa_q    <= 1'b1;
            berr_q   <= 1'b1;
            boot_q   <= 1'b0;
            wait_cnt <= '0;
            tmo_cnt  <= '0;
            boot_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!bus.AS) begin
                        cs_q     <= dec_cs;
                        wait_cnt <= dec_wait;
                        tmo_cnt  <= '0;
                        state    <= dec_state;
                    end
                end
                S_WAIT: begin
                    if (bus.AS) begin
                        // Aborted cycle: release everything, no BOOT credit.
                        cs_q  <= CS_NONE;
                        state <= S_IDLE;
                    end else if (wait_cnt == '0) begin
                        // Wait count wins a same-edge tie with the timeout.
                        dtack_q <= 1'b0;
                        state   <= S_ACK;
                    end else if (tmo_cnt == TMO_LAST) begin
                        berr_q <= 1'b0;
                        state  <= S_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                        tmo_cnt  <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_IACK: begin
                    if (bus.AS) begin
                        state <= S_IDLE;
                    end else begin
                        vpa_q <= 1'b0;
                        state <= S_ACK;
                    end
                end
                S_UNMAPPED: begin
                    if (bus.AS) begin
                        state <= S_IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        berr_q <= 1'b0;
                        state  <= S_ACK;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_ACK: begin
                    if (bus.AS) begin
                        cs_q    <= CS_NONE;
                        dtack_q <= 1'b1;
                        vpa_q   <= 1'b1;
                        berr_q  <= 1'b1;
                        state   <= S_IDLE;
                        // Completed cycle counts toward releasing the overlay; sticky once set.
                        if (!boot_q) begin
                            boot_cnt <= boot_cnt + BOOT_W'(1);
                            if (boot_cnt == BOOT_LAST) begin
                                boot_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    cs_q    <= CS_NONE;
                    dtack_q <= 1'b1;
                    vpa_q   <= 1'b1;
                    berr_q  <= 1'b1;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.CS_ROM = cs_q[2];
    assign bus.CS_RAM = cs_q[1];
    assign bus.CS_IO  = cs_q[0];
    assign bus.DTACK  = dtack_q;
    assign bus.VPA    = vpa_q;
    assign bus.BERR   = berr_q;
    assign bus.BOOT   = boot_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb_bus_cycle_ctrl: directed and randomized bus cycles against a cycle-level
// reference model of bus_cycle_ctrl (region rules, acknowledge edge, boot count).
module tb_bus_cycle_ctrl;

    localparam int unsigned ROM_WAIT    = 2;
    localparam int unsigned RAM_WAIT    = 0;
    localparam int unsigned IO_WAIT     = 4;
    localparam int unsigned TIMEOUT     = 64;
    localparam int unsigned BOOT_CYCLES = 8;

    localparam int R_ROM   = 0;
    localparam int R_RAM   = 1;
    localparam int R_IO    = 2;
    localparam int R_IACK  = 3;
    localparam int R_UNMAP = 4;

    logic CLK;
    logic RST;
    bus_cycle_ctrl_if bus ();

    bus_cycle_ctrl #(
        .ROM_WAIT    (ROM_WAIT),
        .RAM_WAIT    (RAM_WAIT),
        .IO_WAIT     (IO_WAIT),
        .TIMEOUT     (TIMEOUT),
        .BOOT_CYCLES (BOOT_CYCLES)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_vec  = 0;
    int n_miss = 0;
    int boot_count = 0;   // completed cycles seen by the model since reset

    function automatic logic boot_m();
        return (boot_count >= int'(BOOT_CYCLES));
    endfunction

    function automatic int region_of(input logic [2:0] fc, input logic rw, input logic [3:0] addr);
        if (fc == 3'b111)         return R_IACK;
        if (!boot_m() && rw)      return R_ROM;
        if (int'(addr) <= 11)     return R_RAM;
        if (int'(addr) == 14)     return R_ROM;
        if (int'(addr) == 15)     return R_IO;
        return R_UNMAP;
    endfunction

    // Offset (edges after the start edge) at which the acknowledge appears.
    function automatic int ack_edge(input int region);
        int w;
        case (region)
            R_ROM:   w = int'(ROM_WAIT);
            R_RAM:   w = int'(RAM_WAIT);
            R_IO:    w = int'(IO_WAIT);
            R_IACK:  return 1;
            default: return int'(TIMEOUT);
        endcase
        return (w + 1 <= int'(TIMEOUT)) ? w + 1 : int'(TIMEOUT);
    endfunction

    // Expected {DTACK, VPA, BERR} once acknowledged.
    function automatic logic [2:0] ack_pat(input int region);
        int w;
        case (region)
            R_ROM:   w = int'(ROM_WAIT);
            R_RAM:   w = int'(RAM_WAIT);
            R_IO:    w = int'(IO_WAIT);
            R_IACK:  return 3'b101;
            default: return 3'b110;
        endcase
        return (w + 1 <= int'(TIMEOUT)) ? 3'b011 : 3'b110;
    endfunction

    function automatic logic [2:0] cs_pat(input int region);
        case (region)
            R_ROM:   return 3'b011;
            R_RAM:   return 3'b101;
            R_IO:    return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic check(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {bus.CS_ROM, bus.CS_RAM, bus.CS_IO, bus.DTACK, bus.VPA, bus.BERR, bus.BOOT};
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed {cs_rom,cs_ram,cs_io,dtack,vpa,berr,boot}=%b expected %b",
                   tag, obs, exp);
        end
    endtask

    // One bus cycle: AS low for the start edge plus 'hold' further edges, then released.
    task automatic do_cycle(input string tag, input logic [2:0] fc, input logic rw,
                            input logic [3:0] addr, input int hold);
        int         region;
        int         k;
        logic [2:0] cs;
        logic [2:0] ack;
        region = region_of(fc, rw, addr);
        k      = ack_edge(region);
        cs     = cs_pat(region);
        ack    = ack_pat(region);
        bus.AS   = 1'b0;
        bus.FC   = fc;
        bus.RW   = rw;
        bus.ADDR = addr;
        for (int j = 0; j <= hold; j++) begin
            tick();
            check($sformatf("%s.edge%0d", tag, j), {cs, (j >= k) ? ack : 3'b111, boot_m()});
        end
        bus.AS = 1'b1;
        tick();
        if (hold >= k && boot_count < int'(BOOT_CYCLES)) boot_count++;
        check($sformatf("%s.release", tag), {6'b111111, boot_m()});
        tick();
        check($sformatf("%s.idle", tag), {6'b111111, boot_m()});
    endtask

    task automatic pulse_reset(input string tag);
        RST    = 1'b1;
        bus.AS = 1'b1;
        boot_count = 0;
        #1;
        check(tag, 7'b1111110);
        @(negedge CLK);
        RST = 1'b0;
        tick();
        check({tag, ".after"}, 7'b1111110);
    endtask

    initial begin
        int         region;
        int         k;
        int         hold;
        logic [2:0] fc;
        logic       rw;
        logic [3:0] addr;

        CLK      = 1'b0;
        RST      = 1'b0;
        bus.AS   = 1'b1;
        bus.RW   = 1'b1;
        bus.FC   = 3'b101;
        bus.ADDR = 4'h0;
        #3;
        pulse_reset("reset");

        // Overlay read of 0x0 goes to ROM, DTACK after N+3.
        do_cycle("boot_rom_read", 3'b110, 1'b1, 4'h0, 4);
        // Cycles 2..8 complete the boot count; BOOT rises after cycle 8.
        for (int i = 2; i <= 8; i++) begin
            do_cycle($sformatf("boot_cyc%0d", i), 3'b101, 1'b1, 4'($urandom_range(0, 15)), 3);
        end
        do_cycle("ram_read_after_boot", 3'b101, 1'b1, 4'h0, 2);
        do_cycle("io_write", 3'b101, 1'b0, 4'hF, 6);

        pulse_reset("reset2");
        do_cycle("ram_write_overlay", 3'b101, 1'b0, 4'h3, 2);
        do_cycle("unmapped_berr", 3'b101, 1'b0, 4'hC, int'(TIMEOUT) + 2);
        do_cycle("iack_vpa", 3'b111, 1'b1, 4'h0, 2);
        // AS seen high at N+2 during IO wait: abort, no boot credit.
        do_cycle("io_abort", 3'b101, 1'b0, 4'hF, 1);

        // Reset in the middle of a ROM wait.
        bus.AS   = 1'b0;
        bus.FC   = 3'b110;
        bus.RW   = 1'b1;
        bus.ADDR = 4'hE;
        tick();
        check("rom_wait_start", 7'b0111110);
        tick();
        check("rom_wait_mid", 7'b0111110);
        pulse_reset("reset_in_wait");
        do_cycle("rom_after_reset", 3'b110, 1'b1, 4'hE, 3);

        // Randomized cycles, including aborts and overlay transitions.
        for (int i = 0; i < 40; i++) begin
            fc     = 3'($urandom_range(0, 7));
            rw     = 1'($urandom_range(0, 1));
            addr   = 4'($urandom_range(0, 15));
            region = region_of(fc, rw, addr);
            k      = ack_edge(region);
            if ($urandom_range(0, 3) == 0) hold = $urandom_range(0, k - 1);
            else                           hold = k + $urandom_range(0, 2);
            do_cycle($sformatf("rand%0d", i), fc, rw, addr, hold);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bus_cycle_ctrl.md
Name: bus_cycle_ctrl

Overview:
Sequences every 68000 bus cycle in the board CPLD. Decodes the address and function code into chip selects. Applies the boot-time ROM overlay and a per-region wait-state count, then drives DTACK. Raises VPA for interrupt-acknowledge cycles and BERR for cycles that get no acknowledge within a timeout. Runs on the CPU clock, between the 68000 bus and the ROM, RAM and IO devices.

Parameters:
ROM_WAIT, 2, wait states added before DTACK for ROM cycles (0-15)
RAM_WAIT, 0, wait states for RAM cycles (0-15)
IO_WAIT, 4, wait states for IO cycles (0-15)
TIMEOUT, 64, clocks from cycle start to BERR when no acknowledge occurs (2-255)
BOOT_CYCLES, 8, completed bus cycles before the ROM overlay is released (1-15)

Ports:
CLK  in  1  CPU clock; all logic on the rising edge
RST  in  1  asynchronous, active-high reset
AS  in  1  68000 address strobe, active low
RW  in  1  1 = read, 0 = write
FC  in  3  68000 function code
ADDR  in  4  CPU A[23:20]
CS_ROM  out  1  ROM select, active low
CS_RAM  out  1  RAM select, active low
CS_IO  out  1  IO select, active low
DTACK  out  1  data acknowledge, active low
VPA  out  1  autovector request, active low
BERR  out  1  bus error, active low
BOOT  out  1  1 = overlay released

Behaviour:
- Reset (async, RST=1): state IDLE. CS_ROM, CS_RAM, CS_IO, DTACK, VPA and BERR all go to 1 immediately. BOOT=0. Boot cycle counter=0. Wait counter=0. Timeout counter=0. Reset during any state aborts the cycle with no glitch on the outputs.
- AS is sampled on the rising edge of CLK. The CPU shares CLK, so no synchronizer is used.
- Region decode is latched at cycle start and held for the whole cycle:
  - FC=111: IACK cycle; no CS.
  - BOOT=0 and RW=1: ROM, whatever the address.
  - ADDR 0x0-0xB: RAM.
  - ADDR 0xC-0xD: unmapped.
  - ADDR 0xE: ROM.
  - ADDR 0xF: IO.
  - While BOOT=0, writes decode normally; the overlay applies to reads only.
- FSM states:
  - IDLE: on an edge N where AS=0, latch the region. The matching CS goes low after edge N. Load the wait counter with the region's WAIT and clear the timeout counter. Go to WAIT (RAM/ROM/IO), IACK or UNMAPPED.
  - WAIT: each edge with wait counter>0 decrements it. The edge that finds it at 0 drives DTACK low and moves to ACK. DTACK is therefore low after edge N+1+WAIT, and after N+1 when WAIT=0.
  - IACK: VPA low after edge N+1, then go to ACK. No DTACK is driven.
  - UNMAPPED: no CS and no DTACK. The timeout counter increments each edge. BERR goes low after edge N+TIMEOUT, then go to ACK.
  - ACK: hold CS and DTACK/VPA/BERR until an edge samples AS=1. On that edge all outputs return to 1 and the state returns to IDLE.
- Timeout: the counter is 8 bits and also runs in WAIT. If TIMEOUT is reached before the wait count finishes, BERR is asserted instead of DTACK.
- Aborted cycle: AS=1 sampled in WAIT, IACK or UNMAPPED means all outputs return to 1 on that edge and the state returns to IDLE. An aborted cycle does not count toward BOOT.
- Back-to-back cycles: a cycle can start on the edge after the return to IDLE. AS must be seen high for at least one edge between cycles.
- BOOT: the boot cycle counter (4 bits) increments on each ACK->IDLE transition while BOOT=0. The edge that raises the count to BOOT_CYCLES sets BOOT=1. BOOT is sticky until reset and the counter stops.
- Mutual exclusion: at most one of CS_ROM/CS_RAM/CS_IO is low at any time, and at most one of DTACK/VPA/BERR is low at any time.

Test Plan:
- Reset then a read of ADDR=0x0 with RW=1 -> CS_ROM low after start edge N. DTACK low after N+3 (ROM_WAIT=2). CS_RAM stays 1. Outputs return to 1 on the edge sampling AS=1.
- Nine read cycles after reset -> BOOT=0 through cycle 7. BOOT=1 after the ACK->IDLE edge of cycle 8. Cycle 9 at ADDR=0x0 asserts CS_RAM, with DTACK low after N+1.
- Write to ADDR=0xF with BOOT=1 -> CS_IO low after N, DTACK low after N+5. Write to ADDR=0x3 with BOOT=0 -> CS_RAM, not CS_ROM.
- ADDR=0xC -> no CS and no DTACK. BERR low after N+64 and held until AS=1. FC=111 -> VPA low after N+1, no CS.
- AS released during IO WAIT at N+2 -> CS_IO=1 on that edge, DTACK never low, BOOT counter unchanged.
- RST pulsed during ROM WAIT -> all outputs 1 immediately, BOOT=0. The next read of ADDR=0xE completes with DTACK after N+3.
